axis_fifo_mc: RTL

Multi-channel AXI4-Stream FIFO: one input stream is demultiplexed by `s_axis_tdest` into `CHANNELS` independent circular queues held in one partitioned memory. The queues are merged back onto a single output stream by a frame-aware round-robin arbiter. It sits between the DMA ingress and per-mode processing blocks, replacing chains of single-queue FIFOs. It also exports per-channel fill level and almost-full status.

---
 rtl/axis_fifo_mc.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/axis_fifo_mc.sv
// axis_fifo_mc: multi-channel AXI4-Stream FIFO.
// One input stream is split by s_axis_tdest into CHANNELS circular queues held
// in a single partitioned memory. The queues are merged back onto one output
// stream by a round-robin arbiter that does not interleave frames.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   s_axis_*             input stream; s_axis_tdest selects the queue
//   m_axis_*             output stream; m_axis_tdest is the source queue
//   status_count         per-channel fill level, CNT_WIDTH bits per channel
//   status_almost_full   per-channel count >= ALMOST_FULL
//   status_full          per-channel count == DEPTH
//
// Build option: define AXIS_FIFO_MC_STATUS_EN to build the per-channel
// status counters. Without it the three status outputs are tied to 0.
module axis_fifo_mc #(
    parameter int CHANNELS    = 4,
    parameter int DEPTH       = 512,
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 1,
    parameter int ALMOST_FULL = DEPTH - 4,
    localparam int DEST_WIDTH = $clog2(CHANNELS),
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    input  logic [USER_WIDTH-1:0]          s_axis_tuser,
    input  logic [DEST_WIDTH-1:0]          s_axis_tdest,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,
    output logic [DEST_WIDTH-1:0]          m_axis_tdest,
    output logic [CHANNELS*CNT_WIDTH-1:0]  status_count,
    output logic [CHANNELS-1:0]            status_almost_full,
    output logic [CHANNELS-1:0]            status_full
);

    localparam int WORD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
    localparam int MEM_WORDS  = CHANNELS * DEPTH;
    localparam int ADR_W      = DEST_WIDTH + ADDR_WIDTH;
    localparam int LAST_BIT   = USER_WIDTH;
    localparam int KEEP_LSB   = USER_WIDTH + 1;
    localparam int DATA_LSB   = USER_WIDTH + 1 + KEEP_WIDTH;

    // Pointers differing only in the MSB means the queue is full.
    localparam logic [CNT_WIDTH-1:0] PTR_MSB = CNT_WIDTH'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    logic [WORD_WIDTH-1:0] mem [MEM_WORDS];
    logic [CNT_WIDTH-1:0]  wr_ptr [CHANNELS];
    logic [CNT_WIDTH-1:0]  rd_ptr [CHANNELS];

    logic [CHANNELS-1:0]   ch_empty;
    logic [CHANNELS-1:0]   ch_full;
    logic [CHANNELS-1:0]   wr_hit;
    logic [CHANNELS-1:0]   rd_hit;

    logic                  wr_en;
    logic [ADR_W-1:0]      wr_addr;

    state_t                state;
    logic [DEST_WIDTH-1:0] lock_ch;
    logic [DEST_WIDTH-1:0] last_grant;
    logic [DEST_WIDTH-1:0] scan_ch;
    logic [DEST_WIDTH-1:0] rr_ch;
    logic                  rr_hit;
    logic [DEST_WIDTH-1:0] sel_ch;
    logic                  sel_ok;
    logic                  load_ok;
    logic                  rd_en;
    logic [ADR_W-1:0]      rd_addr;
    logic [WORD_WIDTH-1:0] rd_word;

    always_comb begin
        ch_empty = '0;
        ch_full  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch_empty[c] = wr_ptr[c] == rd_ptr[c];
            ch_full[c]  = (wr_ptr[c] ^ rd_ptr[c]) == PTR_MSB;
        end
    end

    // ---------------- write side ----------------
    assign s_axis_tready = !ch_full[s_axis_tdest];
    assign wr_en         = s_axis_tvalid && s_axis_tready;
    assign wr_addr       = {s_axis_tdest,
                            wr_ptr[s_axis_tdest][ADDR_WIDTH-1:0]};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {s_axis_tdata, s_axis_tkeep,
                             s_axis_tlast, s_axis_tuser};
        end
    end

    // ---------------- arbiter ----------------
    // First non-empty channel after last_grant, wrapping modulo CHANNELS.
    always_comb begin
        rr_hit  = 1'b0;
        rr_ch   = last_grant;
        scan_ch = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            scan_ch = last_grant + DEST_WIDTH'(i);
            if (!rr_hit && !ch_empty[scan_ch]) begin
                rr_hit = 1'b1;
                rr_ch  = scan_ch;
            end
        end
    end

    // While a frame is open only its channel may be served, even if empty.
    always_comb begin
        if (state == ST_LOCKED) begin
            sel_ch = lock_ch;
            sel_ok = !ch_empty[lock_ch];
        end else begin
            sel_ch = rr_ch;
            sel_ok = rr_hit;
        end
    end

    assign load_ok = !m_axis_tvalid || m_axis_tready;
    assign rd_en   = load_ok && sel_ok;
    assign rd_addr = {sel_ch, rd_ptr[sel_ch][ADDR_WIDTH-1:0]};
    assign rd_word = mem[rd_addr];

    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_hit[c] = wr_en && (s_axis_tdest == DEST_WIDTH'(c));
            rd_hit[c] = rd_en && (sel_ch == DEST_WIDTH'(c));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_hit[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (rd_hit[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
            end
        end
    end

    // ---------------- arbiter FSM + output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            lock_ch       <= '0;
            last_grant    <= DEST_WIDTH'(CHANNELS - 1);
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            m_axis_tdest  <= '0;
        end else if (load_ok) begin
            m_axis_tvalid <= sel_ok;
            if (sel_ok) begin
                m_axis_tdata <= rd_word[DATA_LSB +: DATA_WIDTH];
                m_axis_tkeep <= rd_word[KEEP_LSB +: KEEP_WIDTH];
                m_axis_tlast <= rd_word[LAST_BIT];
                m_axis_tuser <= rd_word[USER_WIDTH-1:0];
                m_axis_tdest <= sel_ch;
                lock_ch      <= sel_ch;
                if (state == ST_IDLE) last_grant <= sel_ch;
                state <= rd_word[LAST_BIT] ? ST_IDLE : ST_LOCKED;
            end
        end
    end

    // ---------------- status ----------------
`ifdef AXIS_FIFO_MC_STATUS_EN
    logic [CNT_WIDTH-1:0] cnt_nxt [CHANNELS];

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_nxt[c] = status_count[c*CNT_WIDTH +: CNT_WIDTH]
                       + CNT_WIDTH'(wr_hit[c])
                       - CNT_WIDTH'(rd_hit[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_count       <= '0;
            status_almost_full <= '0;
            status_full        <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                status_count[c*CNT_WIDTH +: CNT_WIDTH] <= cnt_nxt[c];
                status_almost_full[c] <=
                    cnt_nxt[c] >= CNT_WIDTH'(ALMOST_FULL);
                status_full[c] <= cnt_nxt[c] == PTR_MSB;
            end
        end
    end
`else
    assign status_count       = '0;
    assign status_almost_full = '0;
    assign status_full        = '0;
`endif

endmodule
